// File: rtl/multicycle_ctrl.sv
// Main control FSM for the RV32I multicycle core: sequences the shared ALU and the
// unified memory port, resolves branches, traps illegal opcodes and counts retirements.
module multicycle_ctrl #(
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int unsigned RET_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             Illegal,
  output logic [RET_W-1:0] Retired
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;
  localparam logic [3:0] StJalrAdr  = 4'd10;
  localparam logic [3:0] StJal      = 4'd11;
  localparam logic [3:0] StLui      = 4'd12;
  localparam logic [3:0] StAuipc    = 4'd13;
  localparam logic [3:0] StTrap     = 4'd14;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [3:0]       state_q, state_d;
  logic [RET_W-1:0] retired_q, retired_d;

  logic mem_req, mem_write, ir_write, pc_update, branch, reg_write, br_taken;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (MemReady) state_d = StDecode;
      StDecode: begin
        unique case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpBranch:        state_d = (funct3[2:1] == 2'b01) ? StTrap : StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalrAdr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
      StMemRead:  if (MemReady) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (MemReady) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJalrAdr:  state_d = StJal;
      StJal:      state_d = StAluWb;
      StLui:      state_d = StAluWb;
      StAuipc:    state_d = StAluWb;
      StTrap:     state_d = HALT_ON_ILLEGAL ? StTrap : StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // A retirement is any entry into FETCH except the fetch stall and the trap exit.
  always_comb begin
    retired_d = retired_q;
    if (state_d == StFetch && state_q != StFetch && state_q != StTrap) begin
      retired_d = retired_q + RET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    unique case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = Lt;
      3'b101:  br_taken = ~Lt;
      3'b110:  br_taken = Ltu;
      3'b111:  br_taken = ~Ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_write = 1'b0;
    AdrSrc    = 1'b0;
    ir_write  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    reg_write = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    Illegal   = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ir_write  = MemReady;
        pc_update = MemReady;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr, StJalrAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        AdrSrc    = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb:  reg_write = 1'b1;
      StBranch: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      StLui: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      StAuipc: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StTrap:  Illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    unique case (op)
      OpStore:        ImmSrc = 3'b001;
      OpBranch:       ImmSrc = 3'b010;
      OpJal:          ImmSrc = 3'b011;
      OpLui, OpAuipc: ImmSrc = 3'b100;
      default:        ImmSrc = 3'b000;
    endcase
  end

  // Enables are masked combinationally so an asserted reset silences them immediately.
  assign MemReq   = reset & mem_req;
  assign MemWrite = reset & mem_write;
  assign IRWrite  = reset & ir_write;
  assign PCWrite  = reset & (pc_update | (branch & br_taken));
  assign RegWrite = reset & reg_write;
  assign Retired  = retired_q;

endmodule
